// File: rtl/invert.sv
// Bit-serial two's-complement negator: copies bits up to and including the first 1,
// then inverts the rest of the word. Optional WORD_LEN framing restarts every N bits.
module invert #(
    parameter int WORD_LEN = 0
) (
    input  logic i,
    input  logic rst_n,
    input  logic clk,
    output logic y
);

    logic found;
    logic y_q;
    logic word_end;

    generate
        if (WORD_LEN > 0) begin : g_framed
            localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_LEN - 1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign word_end = (cnt == LAST);
        end else begin : g_unbounded
            assign word_end = 1'b0;
        end
    endgenerate

    // The word-boundary clear takes priority over a 1 arriving on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found <= 1'b0;
            y_q   <= 1'b0;
        end else begin
            y_q   <= i ^ found;
            found <= word_end ? 1'b0 : (found | i);
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_invert.sv
// Randomized bench for invert: unbounded and 4-bit framed instances checked against
// an arithmetic negation model of the bits received since reset / word start.
module tb_invert;

    logic clk;
    logic rst_n;
    logic i;
    logic y0;
    logic y4;

    int num_checks = 0;
    int num_fail   = 0;

    logic [63:0] acc0;
    int          n0;
    logic [63:0] acc4;
    int          n4;

    invert #(.WORD_LEN(0)) dut_unbounded (.i(i), .rst_n(rst_n), .clk(clk), .y(y0));
    invert #(.WORD_LEN(4)) dut_framed    (.i(i), .rst_n(rst_n), .clk(clk), .y(y4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    // Entered and left at a falling edge; expected bit is the matching bit of -(value so far).
    task automatic applyStimulus(input logic b);
        logic [63:0] neg;
        logic        exp0;
        logic        exp4;
        int          p;
        i = b;
        acc0 = acc0 | (64'(b) << n0);
        neg  = -acc0;
        exp0 = neg[n0];
        n0++;
        p = n4 % 4;
        if (p == 0) acc4 = '0;
        acc4 = acc4 | (64'(b) << p);
        neg  = -acc4;
        exp4 = neg[p];
        n4++;
        @(posedge clk);
        #2;
        checkOutput("y_unbounded", y0, exp0);
        checkOutput("y_framed4", y4, exp4);
        @(negedge clk);
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_y0", y0, 1'b0);
        checkOutput("async_reset_y4", y4, 1'b0);
        i = 1'($urandom);
        @(posedge clk);
        #2;
        checkOutput("held_reset_y0", y0, 1'b0);
        checkOutput("held_reset_y4", y4, 1'b0);
        acc0 = '0;
        n0   = 0;
        acc4 = '0;
        n4   = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applySeq(input logic [15:0] bits, input int len);
        for (int k = 0; k < len; k++) applyStimulus(bits[k]);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i     = 1'b0;
        acc0  = '0;
        n0    = 0;
        acc4  = '0;
        n4    = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            i = 1'($urandom);
            #2;
            checkOutput("power_on_reset_y0", y0, 1'b0);
            checkOutput("power_on_reset_y4", y4, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic negation 52 -> -52");
        applySeq(16'b110100, 6);

        $display("[TB] all-zero word");
        doReset();
        applySeq(16'h0000, 8);

        $display("[TB] first bit is 1");
        doReset();
        applySeq(16'b1001, 4);

        $display("[TB] mid-stream reset");
        doReset();
        applySeq(16'b01, 2);
        doReset();
        applySeq(16'b110, 3);

        $display("[TB] framed words 0,1,0,0 / 1,1,0,1");
        doReset();
        applySeq(16'b1011_0010, 8);

        $display("[TB] randomized streams");
        for (int t = 0; t < 40; t++) begin
            int len;
            int zero_bias;
            doReset();
            len       = $urandom_range(50, 1);
            zero_bias = $urandom_range(3, 0);
            for (int k = 0; k < len; k++) begin
                logic b;
                b = ($urandom_range(3, 0) >= zero_bias) ? 1'($urandom) : 1'b0;
                applyStimulus(b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
